// File: rtl/request_buffer_pkg.sv
// Shared defaults, source encoding and width helpers for the two-channel request buffer.
package request_buffer_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        SRC_C0 = 1'b0,
        SRC_C1 = 1'b1
    } src_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_w(DEF_DEPTH);
    localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);

endpackage

// File: rtl/req_fifo_channel.sv
// One client's request FIFO: power-of-two depth, head exposed combinationally,
// pushes on a full FIFO are dropped and flagged.
module req_fifo_channel
    import request_buffer_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              nonempty,
    output logic              drop
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the registered count, so a same-edge pop never frees room for a push.
    assign full     = (count == FULL_CNT);
    assign nonempty = (count != '0);
    assign drop     = push & full;
    assign do_push  = push & ~full;
    assign do_pop   = pop & nonempty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/request_buffer_2ch.sv
// Two-client request buffer feeding the arbiter: raises R0/R1 from FIFO occupancy,
// pops on a valid grant and registers the popped token with its source.
module request_buffer_2ch
    import request_buffer_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push0,
    input  logic [DATA_W-1:0] data0_in,
    output logic              full0,
    input  logic              push1,
    input  logic [DATA_W-1:0] data1_in,
    output logic              full1,
    output logic              R0,
    output logic              R1,
    input  logic              G0,
    input  logic              G1,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              overflow,
    output logic              grant_err
);

    logic [DATA_W-1:0] head0;
    logic [DATA_W-1:0] head1;
    logic              drop0;
    logic              drop1;
    logic              valid_g0;
    logic              valid_g1;
    logic              bad_grant;
    src_e              src_q;

    assign valid_g0  = G0 & ~G1 & R0;
    assign valid_g1  = G1 & ~G0 & R1;
    assign bad_grant = (G0 & G1) | (G0 & ~R0) | (G1 & ~R1);
    assign out_src   = src_q;

    req_fifo_channel #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ch0 (
        .clock    (clock),
        .reset    (reset),
        .push     (push0),
        .data_in  (data0_in),
        .pop      (valid_g0),
        .data_out (head0),
        .full     (full0),
        .nonempty (R0),
        .drop     (drop0)
    );

    req_fifo_channel #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ch1 (
        .clock    (clock),
        .reset    (reset),
        .push     (push1),
        .data_in  (data1_in),
        .pop      (valid_g1),
        .data_out (head1),
        .full     (full1),
        .nonempty (R1),
        .drop     (drop1)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            src_q     <= SRC_C0;
            overflow  <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            out_valid <= valid_g0 | valid_g1;
            if (valid_g0) begin
                out_data <= head0;
                src_q    <= SRC_C0;
            end else if (valid_g1) begin
                out_data <= head1;
                src_q    <= SRC_C1;
            end
            if (drop0 | drop1)
                overflow <= 1'b1;
            if (bad_grant)
                grant_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_request_buffer_2ch.sv
// Scoreboard bench for request_buffer_2ch: a queue model of both FIFOs predicts
// flags and popped tokens every cycle.
module tb_request_buffer_2ch;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;

    typedef struct {
        logic              src;
        logic [DATA_W-1:0] data;
    } tok_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              push0 = 1'b0;
    logic [DATA_W-1:0] data0_in = '0;
    logic              full0;
    logic              push1 = 1'b0;
    logic [DATA_W-1:0] data1_in = '0;
    logic              full1;
    logic              R0;
    logic              R1;
    logic              G0 = 1'b0;
    logic              G1 = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              overflow;
    logic              grant_err;

    request_buffer_2ch #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .push0     (push0),
        .data0_in  (data0_in),
        .full0     (full0),
        .push1     (push1),
        .data1_in  (data1_in),
        .full1     (full1),
        .R0        (R0),
        .R1        (R1),
        .G0        (G0),
        .G1        (G1),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .overflow  (overflow),
        .grant_err (grant_err)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    tok_t              sb[$];
    logic              m_ovf = 1'b0;
    logic              m_gerr = 1'b0;
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_src = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply current inputs to the model, clock once, then compare outputs.
    task automatic step();
        logic r0, r1, f0, f1, vg0, vg1;
        tok_t t, e;
        r0  = (q0.size() != 0);
        r1  = (q1.size() != 0);
        f0  = (q0.size() == DEPTH);
        f1  = (q1.size() == DEPTH);
        vg0 = G0 && !G1 && r0;
        vg1 = G1 && !G0 && r1;
        if (reset) begin
            q0.delete();
            q1.delete();
            sb.delete();
            m_ovf = 1'b0;
            m_gerr = 1'b0;
            m_valid = 1'b0;
            m_data = '0;
            m_src = 1'b0;
        end else begin
            if ((G0 && G1) || (G0 && !r0) || (G1 && !r1))
                m_gerr = 1'b1;
            if (vg0) begin
                t.src = 1'b0; t.data = q0.pop_front(); sb.push_back(t);
            end
            if (vg1) begin
                t.src = 1'b1; t.data = q1.pop_front(); sb.push_back(t);
            end
            if (push0) begin
                if (f0) m_ovf = 1'b1; else q0.push_back(data0_in);
            end
            if (push1) begin
                if (f1) m_ovf = 1'b1; else q1.push_back(data1_in);
            end
            m_valid = vg0 || vg1;
        end
        @(posedge clock);
        #1;
        check_val("out_valid", out_valid, m_valid);
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                m_data = e.data;
                m_src = e.src;
            end
        end
        check_val("out_data", out_data, m_data);
        check_val("out_src", out_src, m_src);
        check_val("R0", R0, q0.size() != 0);
        check_val("R1", R1, q1.size() != 0);
        check_val("full0", full0, q0.size() == DEPTH);
        check_val("full1", full1, q1.size() == DEPTH);
        check_val("overflow", overflow, m_ovf);
        check_val("grant_err", grant_err, m_gerr);
    endtask

    task automatic idle(input int n);
        push0 = 1'b0; push1 = 1'b0; G0 = 1'b0; G1 = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        push0 = 1'b0; push1 = 1'b0; G0 = 1'b0; G1 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push_ch(input int ch, input logic [DATA_W-1:0] d);
        push0 = (ch == 0); data0_in = d;
        push1 = (ch == 1); data1_in = d;
        step();
        push0 = 1'b0; push1 = 1'b0;
    endtask

    task automatic grant(input logic g0, input logic g1, input int n);
        G0 = g0; G1 = g1;
        for (int i = 0; i < n; i++) step();
        G0 = 1'b0; G1 = 1'b0;
    endtask

    initial begin
        // Reset state and reset mid-operation.
        do_reset();
        step();
        push_ch(0, 8'hA1);
        push_ch(0, 8'hA2);
        do_reset();
        grant(1'b1, 1'b0, 1);
        idle(1);

        // Single client ordering.
        do_reset();
        push_ch(0, 8'h11);
        push_ch(0, 8'h22);
        push_ch(0, 8'h33);
        grant(1'b1, 1'b0, 3);
        idle(2);

        // Fill, overflow and pointer wrap on channel 1.
        do_reset();
        for (int i = 1; i <= 5; i++) push_ch(1, 8'(i));
        grant(1'b0, 1'b1, 2);
        push_ch(1, 8'h06);
        push_ch(1, 8'h07);
        grant(1'b0, 1'b1, 4);
        idle(2);

        // Interleaved clients.
        do_reset();
        push0 = 1'b1; data0_in = 8'hC0; push1 = 1'b1; data1_in = 8'hD0; step();
        push0 = 1'b1; data0_in = 8'hC1; push1 = 1'b1; data1_in = 8'hD1; step();
        push0 = 1'b0; push1 = 1'b0;
        grant(1'b1, 1'b0, 1);
        grant(1'b0, 1'b1, 1);
        grant(1'b1, 1'b0, 1);
        grant(1'b0, 1'b1, 1);
        idle(2);

        // Same-edge push and pop on a full channel.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_ch(0, 8'h50 + 8'(i));
        push0 = 1'b1; data0_in = 8'hEE; G0 = 1'b1;
        step();
        push0 = 1'b0; G0 = 1'b0;
        idle(1);

        // Illegal simultaneous grants.
        do_reset();
        push_ch(0, 8'h71);
        push_ch(1, 8'h81);
        grant(1'b1, 1'b1, 1);
        idle(2);
        grant(1'b1, 1'b0, 1);
        grant(1'b0, 1'b1, 1);
        idle(1);

        // Randomised traffic with mostly legal grants.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int sel;
            push0 = ($urandom_range(0, 2) != 0); data0_in = 8'($urandom);
            push1 = ($urandom_range(0, 2) != 0); data1_in = 8'($urandom);
            sel = $urandom_range(0, 2);
            G0 = (sel == 1) && (q0.size() != 0);
            G1 = (sel == 2) && (q1.size() != 0);
            step();
        end
        idle(1);
        while (q0.size() != 0) grant(1'b1, 1'b0, 1);
        while (q1.size() != 0) grant(1'b0, 1'b1, 1);
        idle(2);
        check_val("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/request_buffer_2ch.md
Name: request_buffer_2ch

Overview:
Upstream stage of the two-client request arbiter. It holds queued request tokens for client 0 and client 1 in two small FIFOs and drives R0/R1 to the arbiter. It consumes the arbiter's G0/G1 grants to pop the granted entry, then presents that entry's payload and source on a registered output.

Parameters:
DEPTH, 4, entries per client FIFO; power of two, minimum 2.
DATA_W, 8, payload width per request token.

Ports:
clock  input  1  single system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
push0  input  1  client 0 enqueue strobe.
data0_in  input  DATA_W  client 0 payload.
full0  output  1  client 0 FIFO full.
push1  input  1  client 1 enqueue strobe.
data1_in  input  DATA_W  client 1 payload.
full1  output  1  client 1 FIFO full.
R0  output  1  request to arbiter: client 0 FIFO non-empty.
R1  output  1  request to arbiter: client 1 FIFO non-empty.
G0  input  1  grant from arbiter to client 0.
G1  input  1  grant from arbiter to client 1.
out_valid  output  1  one-cycle pulse; popped token is on out_data.
out_data  output  DATA_W  payload of the popped token.
out_src  output  1  0 = client 0, 1 = client 1.
overflow  output  1  sticky: a push was dropped on a full FIFO.
grant_err  output  1  sticky: G0 and G1 both high, or a grant arrived with its R low.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clock.
  - Clears both FIFO pointers and counts.
  - Drives R0=R1=0, full0=full1=0, out_valid=0, out_data=0, out_src=0, overflow=0, grant_err=0.
  - Reset asserted mid-operation discards all queued tokens. It also suppresses any out_valid that was due in the next cycle.
- Per-channel FIFO:
  - Count width is clog2(DEPTH+1). Read and write pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
  - fullN = (countN == DEPTH).
  - RN = (countN != 0). RN and fullN are decoded from registered counts, so they change the cycle after the push or pop that alters the count.
- Push:
  - pushN with fullN=0 writes dataN_in at the write pointer; countN increments.
  - pushN with fullN=1 drops the data and sets overflow. This applies even if a pop happens on the same channel in the same cycle: full is judged on the pre-edge count.
- Pop (grant consumption):
  - Valid grant: exactly one of G0/G1 is high, and the matching R is high in the same cycle.
  - A valid grant pops the head entry of that channel.
  - Next cycle: out_valid=1, out_data=popped payload, out_src=channel. Latency is one cycle from grant to out_valid.
  - A grant held high for consecutive cycles pops one entry per cycle while R stays high.
- Simultaneous push and pop on one channel: both take effect and count is unchanged. When count was 0, RN was low, so the grant is invalid and only the push occurs.
- Invalid grants:
  - G0 and G1 both high: no pop on either channel; grant_err is set.
  - GN high with RN low: no pop; grant_err is set.
- out_valid is 0 in any cycle not following a valid grant. out_data and out_src hold their last values when out_valid=0.
- overflow and grant_err clear only on reset.

Decomposition:
- Shared package request_buffer_pkg:
  - Default DEPTH and DATA_W.
  - Source encodings SRC_C0=0 and SRC_C1=1.
  - Count- and pointer-width helper constants.
- One sub-module, req_fifo_channel, instantiated twice.
  - Ports: clock, reset, push, data_in, pop, data_out, full, nonempty, drop.
  - Top level holds grant validation, output register and sticky flags.

Test Plan:
- Reset behaviour: push0 with 0xA1, 0xA2, then assert reset for one cycle -> next cycle R0=0, full0=0, count 0. A G0 pulse afterwards sets grant_err=1, and out_valid stays 0.
- Single client ordering: push0 0x11, 0x22, 0x33; hold G0 high 3 cycles starting when R0=1 -> out_valid high for 3 consecutive cycles with out_data 0x11, 0x22, 0x33, out_src=0. R0 drops the cycle after the third pop.
- Fill and wrap: push1 with 5 tokens 0x01..0x05 at DEPTH=4 -> full1=1 after the 4th push, 5th push dropped, overflow=1. Pop 2, push 0x06, 0x07 (pointer wrap), pop 4 -> outputs 0x03, 0x04, 0x06, 0x07 with out_src=1.
- Interleaved clients: both FIFOs hold 2 tokens (0xC0,0xC1 and 0xD0,0xD1); grants G0,G1,G0,G1 -> out_data sequence 0xC0, 0xD0, 0xC1, 0xD1 with out_src 0,1,0,1.
- Same-cycle push and pop at full: channel 0 full, same edge push0=1 (0xEE) and G0=1 -> head popped, 0xEE dropped, overflow=1, full0=0 the next cycle.
- Illegal grants: both FIFOs non-empty, G0=G1=1 for one cycle -> no pop, out_valid=0, counts unchanged, grant_err=1 until reset.
